exp_golomb_stream_encoder: RTL and testbench

Parametrised, fully pipelined Exp-Golomb encoder for the H.264 encoder's entropy-coding path. It computes codewords arithmetically, with no SD-card or BRAM lookup table. It accepts one syntax element per cycle over a valid/ready handshake, supports ue(v) and optionally se(v) mapping, and emits a right-aligned codeword plus its bit length to the downstream bitstream packer. A running bit counter gives the slice-level rate control the number of bits produced.

---
 rtl/exp_golomb_stream_encoder_if.sv | 30 +++
 rtl/exp_golomb_stream_encoder.sv | 110 +++++++++++
 tb/tb_exp_golomb_stream_encoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exp_golomb_stream_encoder_if.sv
// rtl/exp_golomb_stream_encoder_if.sv - element-in / codeword-out handshake bundle
//
// s_valid, s_ready, s_data, s_se : syntax element into the encoder
// m_valid, m_ready, m_code, m_len : right-aligned codeword and its bit length out
// slave modport is the encoder's view, master modport is the producer/consumer view.
interface exp_golomb_stream_encoder_if #(
   parameter int DATA_W = 16
);
   localparam int CODE_W = 2 * DATA_W + 1;
   localparam int LEN_W  = $clog2(CODE_W + 1);

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_se;
   logic              m_valid;
   logic              m_ready;
   logic [CODE_W-1:0] m_code;
   logic [LEN_W-1:0]  m_len;

   modport slave (
      input  s_valid, s_data, s_se, m_ready,
      output s_ready, m_valid, m_code, m_len
   );

   modport master (
      output s_valid, s_data, s_se, m_ready,
      input  s_ready, m_valid, m_code, m_len
   );
endinterface

// File: rtl/exp_golomb_stream_encoder.sv
// rtl/exp_golomb_stream_encoder.sv - two-stage arithmetic Exp-Golomb encoder with bit counter
//
// clk, rst         : clock, synchronous active-high reset
// bus (slave)      : s_valid/s_ready/s_data/s_se element input,
//                    m_valid/m_ready/m_code/m_len codeword output
// clear            : synchronous clear of bit_count
// bit_count        : bits handed off downstream since reset/clear, wraps
// EXPG_SE_EN       : when defined, s_se selects se(v) mapping per element;
//                    otherwise every element is encoded as ue(v).
module exp_golomb_stream_encoder #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   exp_golomb_stream_encoder_if.slave  bus,
   input  logic                        clear,
   output logic [CNT_W-1:0]            bit_count
);
   localparam int CODE_W = 2 * DATA_W + 1;
   localparam int LEN_W  = $clog2(CODE_W + 1);

   logic              s1_valid;
   logic [DATA_W:0]   s1_k;
   logic              m_valid_q;
   logic [CODE_W-1:0] m_code_q;
   logic [LEN_W-1:0]  m_len_q;

   logic              adv2;
   logic              s1_load;
   logic              fire;
   logic [DATA_W:0]   k_next;
   logic [DATA_W:0]   x;
   logic [LEN_W-2:0]  msb;

   assign adv2        = !m_valid_q || bus.m_ready;
   assign s1_load     = !s1_valid || adv2;
   assign fire        = m_valid_q && bus.m_ready;

   assign bus.s_ready = s1_load;
   assign bus.m_valid = m_valid_q;
   assign bus.m_code  = m_code_q;
   assign bus.m_len   = m_len_q;

`ifdef EXPG_SE_EN
   // se(v): 2v fits in DATA_W+1 bits once the sign bit is dropped; for v<=0
   // negating the truncated 2v gives -2v exactly, including 2^DATA_W for the
   // most negative input.
   logic [DATA_W:0] two_v;
   assign two_v = {bus.s_data, 1'b0};

   always_comb begin
      k_next = {1'b0, bus.s_data};
      if (bus.s_se) begin
         if (!bus.s_data[DATA_W-1] && (|bus.s_data))
            k_next = two_v - (DATA_W + 1)'(1);
         else
            k_next = -two_v;
      end
   end
`else
   logic unused_s_se;
   assign unused_s_se = bus.s_se;
   assign k_next      = {1'b0, bus.s_data};
`endif

   // k <= 2^DATA_W - 1 except the se extreme 2^DATA_W, so k+1 never wraps.
   assign x = s1_k + (DATA_W + 1)'(1);

   // Leading-one position of x; x is never zero.
   always_comb begin
      msb = '0;
      for (int i = 0; i <= DATA_W; i++)
         if (x[i])
            msb = (LEN_W - 1)'(i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_k      <= '0;
         m_valid_q <= 1'b0;
         m_code_q  <= '0;
         m_len_q   <= '0;
      end else begin
         if (adv2) begin
            m_valid_q <= s1_valid;
            if (s1_valid) begin
               // M leading zeros come for free from right-aligning x.
               m_code_q <= {{DATA_W{1'b0}}, x};
               m_len_q  <= {msb, 1'b1};
            end
         end
         if (s1_load) begin
            s1_valid <= bus.s_valid;
            if (bus.s_valid)
               s1_k <= k_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         bit_count <= '0;
      else if (clear)
         bit_count <= fire ? CNT_W'(m_len_q) : '0;
      else if (fire)
         bit_count <= bit_count + CNT_W'(m_len_q);
   end
endmodule

// File: tb/tb_exp_golomb_stream_encoder.sv
// tb/tb_exp_golomb_stream_encoder.sv - directed table-driven bench for exp_golomb_stream_encoder
module tb_exp_golomb_stream_encoder;
   localparam int DATA_W = 16;

   typedef struct {
      logic [15:0] data;
      logic        se;
      logic [32:0] code;
      logic [5:0]  len;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [31:0] bit_count;

   exp_golomb_stream_encoder_if #(.DATA_W(DATA_W)) bus ();

   exp_golomb_stream_encoder #(.DATA_W(DATA_W), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clear     (clear),
      .bit_count (bit_count)
   );

   always #5 clk = ~clk;

   int    n_checks = 0;
   int    n_pass   = 0;
   vec_t  tbl[$];
   vec_t  exp_q[$];
   logic        stall_q = 1'b0;
   logic [32:0] held_code;
   logic [5:0]  held_len;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req)
         n_pass++;
      else
         $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: checks order/content of every handed-off codeword and
   // that a stalled codeword stays put.
   always @(negedge clk) begin
      vec_t e;
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("hold_valid", 64'(bus.m_valid), 64'(1));
            check("hold_code", 64'(bus.m_code), 64'(held_code));
            check("hold_len", 64'(bus.m_len), 64'(held_len));
         end
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL spurious_output: got code %0h len %0d, required no output",
                        bus.m_code, bus.m_len);
            end else begin
               e = exp_q.pop_front();
               check("out_code", 64'(bus.m_code), 64'(e.code));
               check("out_len", 64'(bus.m_len), 64'(e.len));
            end
         end
         stall_q   = bus.m_valid && !bus.m_ready;
         held_code = bus.m_code;
         held_len  = bus.m_len;
      end
   end

   // Present one element until it is accepted; optionally expect it on the output.
   task automatic send_one(input logic [15:0] d, input logic se, input bit expect_out,
                           input logic [32:0] code, input logic [5:0] len);
      bit acc = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_se    = se;
      if (expect_out)
         exp_q.push_back('{d, se, code, len});
      for (int t = 0; t < 20 && !acc; t++) begin
         #1;
         acc = bus.s_ready;
         tick();
      end
      if (!acc)
         check("send_accept_timeout", 64'(acc), 64'(1));
      bus.s_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && exp_q.size() != 0; t++)
         tick();
      check("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned sum_len;
      int          sent, got, occ;
      bit          saw_low;
      bit          acc, fr;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_se    = 1'b0;
      bus.m_ready = 1'b0;

      // Vector table: hand-computed codewords.
      tbl.push_back('{16'd0,     1'b0, 33'h00001, 6'd1});
      tbl.push_back('{16'd1,     1'b0, 33'h00002, 6'd3});
      tbl.push_back('{16'd2,     1'b0, 33'h00003, 6'd3});
      tbl.push_back('{16'd3,     1'b0, 33'h00004, 6'd5});
      tbl.push_back('{16'd7,     1'b0, 33'h00008, 6'd7});
      tbl.push_back('{16'hFFFF,  1'b0, 33'h10000, 6'd33});
`ifdef EXPG_SE_EN
      tbl.push_back('{16'h0001,  1'b1, 33'h00002, 6'd3});
      tbl.push_back('{16'hFFFF,  1'b1, 33'h00003, 6'd3});
      tbl.push_back('{16'h0002,  1'b1, 33'h00004, 6'd5});
      tbl.push_back('{16'hFFFE,  1'b1, 33'h00005, 6'd5});
      tbl.push_back('{16'h0000,  1'b1, 33'h00001, 6'd1});
      tbl.push_back('{16'h8000,  1'b1, 33'h10001, 6'd33});
      tbl.push_back('{16'h7FFF,  1'b1, 33'h0FFFE, 6'd31});
`else
      tbl.push_back('{16'hFFFF,  1'b1, 33'h10000, 6'd33});
      tbl.push_back('{16'h0002,  1'b1, 33'h00003, 6'd3});
`endif

      // Reset state.
      tick();
      tick();
      rst = 1'b0;
      check("rst_m_valid", 64'(bus.m_valid), 64'(0));
      check("rst_m_code", 64'(bus.m_code), 64'(0));
      check("rst_m_len", 64'(bus.m_len), 64'(0));
      check("rst_bit_count", 64'(bit_count), 64'(0));
      #1;
      check("rst_s_ready", 64'(bus.s_ready), 64'(1));

      // Streaming table with m_ready held high.
      bus.m_ready = 1'b1;
      sum_len = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = tbl[i].data;
         bus.s_se    = tbl[i].se;
         exp_q.push_back(tbl[i]);
         sum_len += tbl[i].len;
         #1;
         check("stream_s_ready", 64'(bus.s_ready), 64'(1));
         tick();
         if (i == 0)
            check("latency_first_edge", 64'(bus.m_valid), 64'(0));
         else
            check("back_to_back_valid", 64'(bus.m_valid), 64'(1));
      end
      bus.s_valid = 1'b0;
      drain();
      check("table_bit_count", 64'(bit_count), 64'(sum_len));

      // Clear alone.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_alone", 64'(bit_count), 64'(0));

      // bit_count accumulation: 1 + 5 + 7.
      send_one(16'd0, 1'b0, 1, 33'h1, 6'd1);
      send_one(16'd3, 1'b0, 1, 33'h4, 6'd5);
      send_one(16'd7, 1'b0, 1, 33'h8, 6'd7);
      drain();
      check("bit_count_13", 64'(bit_count), 64'(13));

      // Clear coinciding with a 3-bit beat.
      bus.m_ready = 1'b0;
      send_one(16'd1, 1'b0, 1, 33'h2, 6'd3);
      for (int t = 0; t < 10 && !bus.m_valid; t++)
         tick();
      check("clear_beat_ready", 64'(bus.m_valid), 64'(1));
      bus.m_ready = 1'b1;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clear_with_beat", 64'(bit_count), 64'(3));

      // Backpressure: m_ready toggles, 10 elements ue 0..9.
      begin
         logic [5:0] bp_len [10] = '{6'd1, 6'd3, 6'd3, 6'd5, 6'd5, 6'd5, 6'd5, 6'd7, 6'd7, 6'd7};
         sent = 0; got = 0; occ = 0; saw_low = 0;
         for (int c = 0; c < 80 && got < 10; c++) begin
            bus.m_ready = (c % 2 == 1);
            bus.s_valid = (sent < 10);
            bus.s_data  = 16'(sent);
            bus.s_se    = 1'b0;
            #1;
            check("bp_s_ready", 64'(bus.s_ready), 64'((occ < 2) || bus.m_ready));
            if (!bus.s_ready && occ == 2)
               saw_low = 1;
            acc = bus.s_valid && bus.s_ready;
            fr  = bus.m_valid && bus.m_ready;
            if (acc)
               exp_q.push_back('{16'(sent), 1'b0, 33'(sent + 1), bp_len[sent]});
            tick();
            if (acc) begin sent++; occ++; end
            if (fr)  begin got++;  occ--; end
         end
         bus.s_valid = 1'b0;
         check("bp_all_delivered", 64'(got), 64'(10));
         check("bp_s_ready_dropped", 64'(saw_low), 64'(1));
         drain();
      end

      // Reset with two elements buffered.
      bus.m_ready = 1'b0;
      send_one(16'd100, 1'b0, 0, 33'h0, 6'd0);
      send_one(16'd200, 1'b0, 0, 33'h0, 6'd0);
      #1;
      check("full_s_ready_low", 64'(bus.s_ready), 64'(0));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      check("midrst_m_valid", 64'(bus.m_valid), 64'(0));
      check("midrst_bit_count", 64'(bit_count), 64'(0));
      #1;
      check("midrst_s_ready", 64'(bus.s_ready), 64'(1));
      bus.m_ready = 1'b1;
      for (int t = 0; t < 4; t++) begin
         tick();
         check("midrst_no_ghost", 64'(bus.m_valid), 64'(0));
      end
      send_one(16'd4, 1'b0, 1, 33'h5, 6'd5);
      drain();
      check("post_rst_bit_count", 64'(bit_count), 64'(5));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
